neuron_delay: RTL and testbench



---
 rtl/neuron_delay_pkg.sv | 11 +
 rtl/neuron_delay_tick.sv | 46 ++++
 rtl/neuron_delay.sv | 59 +++++
 tb/tb_neuron_delay.sv | 130 +++++++++++++
 4 files changed

// File: rtl/neuron_delay_pkg.sv
// rtl/neuron_delay_pkg.sv - shared constants and depth helper for the neuron spike-delay line
package neuron_delay_pkg;

  localparam int DV_W_DEFAULT = 3;

  // Shift-register depth implied by a delay_value width
  function automatic int max_delay(input int dv_w);
    return (1 << dv_w) - 1;
  endfunction

endpackage

// File: rtl/neuron_delay_tick.sv
// rtl/neuron_delay_tick.sv - delay_clk sampler and rising-edge tick generator (DELAY_CLK_SYNC_EN adds a 2-flop synchronizer)
module neuron_delay_tick (
  input  logic sys_clk,
  input  logic reset,
  input  logic delay_clk,
  output logic tick
);

  logic s0;
  logic s1;
  logic delay_clk_in;

`ifdef DELAY_CLK_SYNC_EN
  logic sync0;
  logic sync1;

  // Two-flop synchronizer for an asynchronous delay_clk source
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= delay_clk;
      sync1 <= sync0;
    end
  end

  assign delay_clk_in = sync1;
`else
  assign delay_clk_in = delay_clk;
`endif

  // Sample history used by the rising-edge detector; cleared so no tick fires right after reset
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      s0 <= delay_clk_in;
      s1 <= s0;
    end
  end

  assign tick = s0 & ~s1;

endmodule

// File: rtl/neuron_delay.sv
// rtl/neuron_delay.sv - programmable spike-delay line; optional DELAY_CLK_SYNC_EN synchronizes delay_clk
module neuron_delay
  import neuron_delay_pkg::*;
#(
  parameter int DV_W = DV_W_DEFAULT
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            delay_clk,
  input  logic [DV_W-1:0] delay_value,
  input  logic            delay,
  input  logic            din,
  output logic            dout
);

  localparam int MAX_DELAY = max_delay(DV_W);

  logic                 tick;
  logic                 pend;
  logic [MAX_DELAY:1]   sr;
  logic [MAX_DELAY:0]   taps;
  logic                 bypass;

  neuron_delay_tick u_tick (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .delay_clk (delay_clk),
    .tick      (tick)
  );

  // Tap 0 is tied low so delay_value indexes the stage directly
  assign taps   = {sr, 1'b0};
  assign bypass = ~delay | (delay_value == '0);

  // Sticky capture between ticks, then shift one stage per tick; shifting continues while bypassed
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pend <= 1'b0;
      sr   <= '0;
    end else if (tick) begin
      pend <= 1'b0;
      sr   <= {sr[MAX_DELAY-1:1], pend | din};
    end else begin
      pend <= pend | din;
    end
  end

  // Registered output: straight-through in bypass, otherwise the selected stage
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      dout <= 1'b0;
    end else if (bypass) begin
      dout <= din;
    end else begin
      dout <= taps[delay_value];
    end
  end

endmodule

// File: tb/tb_neuron_delay.sv
// tb/tb_neuron_delay.sv - directed vector bench for neuron_delay
module tb_neuron_delay;

  logic       sys_clk;
  logic       reset;
  logic       delay_clk;
  logic [2:0] delay_value;
  logic       delay;
  logic       din;
  logic       dout;

  int compared;
  int mismatched;

  typedef struct {
    logic       rst;
    logic [2:0] dv;
    logic       dly;
    logic       din;
    logic       exp;
  } vec_t;

  vec_t vecs[12];

  neuron_delay #(.DV_W(3)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .delay_clk   (delay_clk),
    .delay_value (delay_value),
    .delay       (delay),
    .din         (din),
    .dout        (dout)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input int t, input logic got, input logic exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0d dout=%b expected=%b", name, t, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; delay_clk = 1'b0; din = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // delay_clk period 4 (high on phases 0,1); ticks shift sr at the edge of steps 1,5,9,...
  task automatic run_seq(input string name, input int n, input logic [2:0] dv0,
                         input int chg_t, input logic [2:0] dv1, input logic [31:0] din_mask,
                         input int rst_t, input int exp_lo, input int exp_hi);
    for (int t = 0; t < n; t++) begin
      reset       = (t == rst_t);
      delay_clk   = ((t % 4) < 2);
      delay_value = (t >= chg_t) ? dv1 : dv0;
      delay       = 1'b1;
      din         = din_mask[t];
      step();
      check(name, t, dout, (t >= exp_lo) && (t <= exp_hi));
    end
    reset = 1'b0; din = 1'b0; delay_clk = 1'b0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    delay_clk   = 1'b0;
    delay_value = 3'd0;
    delay       = 1'b0;
    din         = 1'b0;

    // reset hold, bypass follow, delay_value=0 bypass, delay=0 with nonzero delay_value
    vecs[0]  = '{rst:1'b1, dv:3'd0, dly:1'b0, din:1'b1, exp:1'b0};
    vecs[1]  = '{rst:1'b1, dv:3'd0, dly:1'b0, din:1'b1, exp:1'b0};
    vecs[2]  = '{rst:1'b0, dv:3'd0, dly:1'b0, din:1'b1, exp:1'b1};
    vecs[3]  = '{rst:1'b0, dv:3'd0, dly:1'b0, din:1'b0, exp:1'b0};
    vecs[4]  = '{rst:1'b0, dv:3'd0, dly:1'b0, din:1'b1, exp:1'b1};
    vecs[5]  = '{rst:1'b0, dv:3'd0, dly:1'b0, din:1'b1, exp:1'b1};
    vecs[6]  = '{rst:1'b0, dv:3'd0, dly:1'b0, din:1'b0, exp:1'b0};
    vecs[7]  = '{rst:1'b0, dv:3'd0, dly:1'b0, din:1'b0, exp:1'b0};
    vecs[8]  = '{rst:1'b0, dv:3'd0, dly:1'b1, din:1'b1, exp:1'b1};
    vecs[9]  = '{rst:1'b0, dv:3'd0, dly:1'b1, din:1'b0, exp:1'b0};
    vecs[10] = '{rst:1'b0, dv:3'd4, dly:1'b0, din:1'b1, exp:1'b1};
    vecs[11] = '{rst:1'b0, dv:3'd4, dly:1'b0, din:1'b0, exp:1'b0};

    for (int i = 0; i < 12; i++) begin
      reset       = vecs[i].rst;
      delay_value = vecs[i].dv;
      delay       = vecs[i].dly;
      din         = vecs[i].din;
      delay_clk   = 1'b0;
      step();
      check($sformatf("vec%0d", i), i, dout, vecs[i].exp);
    end

    // din high on steps 2,3: captured at tick edge 5, reaches sr[4] at edge 17, dout high 18..21
    do_reset();
    run_seq("delay4", 26, 3'd4, 1000, 3'd4, 32'h0000_000C, -1, 18, 21);

    // two separate pulses (steps 2,4) merge: sr[2] at edge 9, dout high 10..13 only
    do_reset();
    run_seq("merge2", 18, 3'd2, 1000, 3'd2, 32'h0000_0014, -1, 10, 13);

    // spike in sr[2] (edges 9..12) while dv=4; dv switched to 2 at step 11 -> dout high 11..13
    do_reset();
    run_seq("dvchange", 22, 3'd4, 11, 3'd2, 32'h0000_0004, -1, 11, 13);

    // reset mid-flight at step 8 drops the spike
    do_reset();
    run_seq("midreset", 26, 3'd4, 1000, 3'd4, 32'h0000_0004, 8, 1000, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
